// File: rtl/img_xfer_pkg.sv
// Shared definitions for the pixel pull protocol between the frame buffer
// responder and the CPU image reader.
package img_xfer_pkg;

   localparam int PIX_W        = 24;
   localparam int FRAME_WIDTH  = 640;
   localparam int FRAME_HEIGHT = 480;
   localparam int FRAME_ADDR_W = 19;
   localparam int RD_LAT_DEF   = 2;

   // Encoding is also decoded by the reader's debug PIO, keep it fixed.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } pix_state_e;

endpackage

// File: rtl/img_pix_server_if.sv
// Pixel pull handshake plus frame-buffer read port, bundled for the responder.
interface img_pix_server_if
   import img_xfer_pkg::*;
#(
   parameter int ADDR_W = FRAME_ADDR_W
);

   logic              cpu_rdy;
   logic              get_next_pix;
   logic              pix_rdy;
   logic [PIX_W-1:0]  pixel_data;
   logic              img_done;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_rdata;
   logic [2:0]        state_out;

   modport slave (
      input  cpu_rdy, get_next_pix, mem_rdata,
      output pix_rdy, pixel_data, img_done, mem_rd, mem_addr, state_out
   );

   modport master (
      output cpu_rdy, get_next_pix, mem_rdata,
      input  pix_rdy, pixel_data, img_done, mem_rd, mem_addr, state_out
   );

endinterface

// File: rtl/img_pix_server_rd_lat_pipe.sv
// Tracks an outstanding frame-buffer read and flags the cycle its data is valid.
module rd_lat_pipe #(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic flush,
   input  logic rd,
   output logic cap
);

   logic [RD_LAT-1:0] sr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr <= '0;
      end else if (flush) begin
         sr <= '0;
      end else begin
         sr <= RD_LAT'({sr, rd});
      end
   end

   assign cap = sr[RD_LAT-1];

endmodule

// File: rtl/img_pix_server.sv
// Frame-buffer-side responder: fetches one pixel per reader request and
// flags end of frame after the last pixel is consumed.
//
// state   | meaning
// IDLE    | no frame requested, address parked at 0
// FETCH   | read strobe to frame buffer for current address
// WAIT    | read in flight, capture data on the strobe from rd_lat_pipe
// PRESENT | pixel valid, waiting for the reader to consume it
// DONE    | last pixel consumed, hold until reader drops cpu_rdy
module img_pix_server
   import img_xfer_pkg::*;
#(
   parameter int WIDTH  = FRAME_WIDTH,
   parameter int HEIGHT = FRAME_HEIGHT,
   parameter int ADDR_W = FRAME_ADDR_W,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input logic             clk,
   input logic             reset_n,
   img_pix_server_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

   pix_state_e        state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [PIX_W-1:0]  pix_q;
   logic              rd;
   logic              cap;
   logic              cap_en;
   logic              flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         addr  <= '0;
         pix_q <= '0;
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
         if (cap_en) begin
            pix_q <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      cap_en    = 1'b0;
      flush     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            addr_nxt = '0;
            if (bus.cpu_rdy) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (!bus.cpu_rdy) begin
               state_nxt = ST_IDLE;
               addr_nxt  = '0;
               flush     = 1'b1;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!bus.cpu_rdy) begin
               state_nxt = ST_IDLE;
               addr_nxt  = '0;
               flush     = 1'b1;
            end else if (cap) begin
               cap_en    = 1'b1;
               state_nxt = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            // Abort takes priority over a same-cycle consume.
            if (!bus.cpu_rdy) begin
               state_nxt = ST_IDLE;
               addr_nxt  = '0;
               flush     = 1'b1;
            end else if (bus.get_next_pix) begin
               if (addr == LAST_ADDR) begin
                  state_nxt = ST_DONE;
               end else begin
                  addr_nxt  = addr + 1'b1;
                  state_nxt = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            if (!bus.cpu_rdy) begin
               state_nxt = ST_IDLE;
               addr_nxt  = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            addr_nxt  = '0;
         end
      endcase
   end

   assign rd = (state == ST_FETCH);

   rd_lat_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_lat_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .rd      (rd),
      .cap     (cap)
   );

   assign bus.mem_rd     = rd;
   assign bus.mem_addr   = addr;
   assign bus.pix_rdy    = (state == ST_PRESENT);
   assign bus.img_done   = (state == ST_DONE);
   assign bus.pixel_data = pix_q;
   assign bus.state_out  = state;

endmodule

// File: tb/tb_img_pix_server.sv
// Directed bench for img_pix_server on a 4x2 frame at read latencies 1, 2 and 4.
module tb_img_pix_server;

   logic        clk;
   logic        reset_n;
   logic        cpu_rdy      [3];
   logic        gnp          [3];
   logic        pix_rdy      [3];
   logic        img_done     [3];
   logic        mem_rd       [3];
   logic [2:0]  maddr        [3];
   logic [2:0]  st           [3];
   logic [23:0] pix          [3];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance g runs with read latency 1, 2, 4; memory word = address * 0x010101,
   // garbage outside the valid cycle so mistimed captures are visible.
   for (genvar g = 0; g < 3; g++) begin : u
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;

      img_pix_server_if #(.ADDR_W(3)) bus ();

      img_pix_server #(
         .WIDTH  (4),
         .HEIGHT (2),
         .ADDR_W (3),
         .RD_LAT (LAT)
      ) dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (bus)
      );

      logic [3:0] vld;
      logic [2:0] adr [4];

      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            vld <= '0;
            for (int k = 0; k < 4; k++) adr[k] <= '0;
         end else begin
            vld    <= {vld[2:0], bus.mem_rd};
            adr[0] <= bus.mem_addr;
            for (int k = 1; k < 4; k++) adr[k] <= adr[k-1];
         end
      end

      assign bus.mem_rdata    = vld[LAT-1] ? {3{5'd0, adr[LAT-1]}} : 24'hBADBAD;
      assign bus.cpu_rdy      = cpu_rdy[g];
      assign bus.get_next_pix = gnp[g];
      assign pix_rdy[g]       = bus.pix_rdy;
      assign img_done[g]      = bus.img_done;
      assign mem_rd[g]        = bus.mem_rd;
      assign maddr[g]         = bus.mem_addr;
      assign st[g]            = bus.state_out;
      assign pix[g]           = bus.pixel_data;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts cycles from the current one until pix_rdy is seen; optional request pulse.
   task automatic measure(input int idx, input bit pulse, output int n);
      n = 0;
      if (pulse) gnp[idx] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         gnp[idx] = 1'b0;
         n++;
         if (pix_rdy[idx]) break;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cpu_rdy[i] = 1'b0;
         gnp[i]     = 1'b0;
      end
      tick(3);
      chk("rst_pix_rdy",  32'(pix_rdy[1]),  32'd0);
      chk("rst_img_done", 32'(img_done[1]), 32'd0);
      chk("rst_mem_rd",   32'(mem_rd[1]),   32'd0);
      chk("rst_mem_addr", 32'(maddr[1]),    32'd0);
      chk("rst_pixel",    32'(pix[1]),      32'd0);
      chk("rst_state",    32'(st[1]),       32'd0);
      reset_n = 1'b1;
      tick(1);

      // Full frame at RD_LAT=2, request 3 cycles after each pix_rdy
      cpu_rdy[1] = 1'b1;
      tick(1);
      chk("start_state", 32'(st[1]),     32'd1);
      chk("start_rd",    32'(mem_rd[1]), 32'd1);
      chk("start_addr",  32'(maddr[1]),  32'd0);
      tick(2);
      chk("start_early", 32'(pix_rdy[1]), 32'd0);
      tick(1);
      chk("start_rdy",   32'(pix_rdy[1]), 32'd1);
      chk("start_pix",   32'(pix[1]),     32'd0);
      for (int i = 0; i < 8; i++) begin
         tick(3);
         chk("hold_rdy", 32'(pix_rdy[1]), 32'd1);
         chk("hold_pix", 32'(pix[1]),     32'(i * 32'h010101));
         gnp[1] = 1'b1;
         tick(1);
         gnp[1] = 1'b0;
         chk("req_rdy_low", 32'(pix_rdy[1]), 32'd0);
         if (i < 7) begin
            chk("req_rd",   32'(mem_rd[1]), 32'd1);
            chk("req_addr", 32'(maddr[1]),  32'(i + 1));
            chk("req_done", 32'(img_done[1]), 32'd0);
            tick(2);
            chk("req_early", 32'(pix_rdy[1]), 32'd0);
            tick(1);
            chk("req_rdy", 32'(pix_rdy[1]), 32'd1);
            chk("req_pix", 32'(pix[1]),     32'((i + 1) * 32'h010101));
         end else begin
            chk("last_done",  32'(img_done[1]), 32'd1);
            chk("last_state", 32'(st[1]),       32'd4);
         end
      end

      // DONE holds while cpu_rdy stays high, requests ignored
      for (int k = 0; k < 10; k++) begin
         gnp[1] = (k == 4);
         tick(1);
         chk("done_hold", 32'(img_done[1]), 32'd1);
         chk("done_rdy",  32'(pix_rdy[1]),  32'd0);
      end
      gnp[1]     = 1'b0;
      cpu_rdy[1] = 1'b0;
      tick(1);
      chk("done_fall",  32'(img_done[1]), 32'd0);
      chk("done_idle",  32'(st[1]),       32'd0);
      cpu_rdy[1] = 1'b1;
      tick(1);
      chk("restart_addr", 32'(maddr[1]), 32'd0);
      chk("restart_rd",   32'(mem_rd[1]), 32'd1);
      tick(3);
      chk("restart_rdy", 32'(pix_rdy[1]), 32'd1);
      chk("restart_pix", 32'(pix[1]),     32'd0);

      // Request pulsed during WAIT is ignored
      gnp[1] = 1'b1;
      tick(1);
      gnp[1] = 1'b0;
      chk("wgnp_addr", 32'(maddr[1]), 32'd1);
      tick(1);
      gnp[1] = 1'b1;
      tick(1);
      gnp[1] = 1'b0;
      chk("wgnp_state", 32'(st[1]),    32'd2);
      chk("wgnp_addr2", 32'(maddr[1]), 32'd1);
      tick(1);
      chk("wgnp_rdy",  32'(pix_rdy[1]), 32'd1);
      chk("wgnp_pix",  32'(pix[1]),     32'h010101);
      chk("wgnp_addr3", 32'(maddr[1]),  32'd1);

      // Abort during WAIT at RD_LAT=2
      gnp[1] = 1'b1;
      tick(1);
      gnp[1] = 1'b0;
      tick(1);
      cpu_rdy[1] = 1'b0;
      tick(1);
      chk("abort_state", 32'(st[1]),      32'd0);
      chk("abort_rdy",   32'(pix_rdy[1]), 32'd0);
      chk("abort_addr",  32'(maddr[1]),   32'd0);
      tick(2);
      chk("abort_pix", 32'(pix[1]), 32'h010101);
      cpu_rdy[1] = 1'b1;
      tick(1);
      chk("abort_re_addr", 32'(maddr[1]), 32'd0);
      tick(3);
      chk("abort_re_rdy", 32'(pix_rdy[1]), 32'd1);
      chk("abort_re_pix", 32'(pix[1]),     32'd0);

      // Reset while presenting a nonzero pixel
      gnp[1] = 1'b1;
      tick(1);
      gnp[1] = 1'b0;
      tick(3);
      chk("pre_rst_pix", 32'(pix[1]), 32'h010101);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_rdy",   32'(pix_rdy[1]),  32'd0);
      chk("mid_rst_state", 32'(st[1]),       32'd0);
      chk("mid_rst_pix",   32'(pix[1]),      32'd0);
      chk("mid_rst_addr",  32'(maddr[1]),    32'd0);
      chk("mid_rst_done",  32'(img_done[1]), 32'd0);
      tick(1);
      reset_n = 1'b1;
      tick(1);
      chk("post_rst_state", 32'(st[1]),    32'd1);
      chk("post_rst_addr",  32'(maddr[1]), 32'd0);
      tick(3);
      chk("post_rst_rdy", 32'(pix_rdy[1]), 32'd1);
      chk("post_rst_pix", 32'(pix[1]),     32'd0);
      cpu_rdy[1] = 1'b0;
      tick(1);

      // Latency sweep, RD_LAT=1
      cpu_rdy[0] = 1'b1;
      measure(0, 1'b0, n);
      chk("lat1_start", 32'(n), 32'd3);
      chk("lat1_pix0",  32'(pix[0]), 32'd0);
      measure(0, 1'b1, n);
      chk("lat1_req",  32'(n), 32'd3);
      chk("lat1_pix1", 32'(pix[0]), 32'h010101);
      cpu_rdy[0] = 1'b0;
      tick(1);

      // Latency sweep, RD_LAT=4
      cpu_rdy[2] = 1'b1;
      measure(2, 1'b0, n);
      chk("lat4_start", 32'(n), 32'd6);
      chk("lat4_pix0",  32'(pix[2]), 32'd0);
      measure(2, 1'b1, n);
      chk("lat4_req",  32'(n), 32'd6);
      chk("lat4_pix1", 32'(pix[2]), 32'h010101);

      // Abort during WAIT at RD_LAT=4 with immediate restart; stale read must be dropped
      gnp[2] = 1'b1;
      tick(1);
      gnp[2] = 1'b0;
      tick(1);
      cpu_rdy[2] = 1'b0;
      tick(1);
      chk("lat4_abort_state", 32'(st[2]), 32'd0);
      cpu_rdy[2] = 1'b1;
      tick(1);
      chk("lat4_re_state", 32'(st[2]), 32'd1);
      tick(2);
      chk("lat4_stale_rdy", 32'(pix_rdy[2]), 32'd0);
      tick(3);
      chk("lat4_re_rdy", 32'(pix_rdy[2]), 32'd1);
      chk("lat4_re_pix", 32'(pix[2]),     32'd0);
      cpu_rdy[2] = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
